// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters; 1-cycle result latency.
// A port is granted only while its result slot is free, so a stalled consumer blocks only its own port.
// Define ALU_ARB_FIXED_PRIORITY_EN to make port 0 always win contention instead of round-robin.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_func,
    input  logic        req0_mod,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_func,
    input  logic        req1_mod,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,

    output logic [31:0] alu_input_a,
    output logic [31:0] alu_input_b,
    output logic [2:0]  alu_function_select,
    output logic        alu_function_modifier,
    input  logic [31:0] alu_result
);

    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp0_result_q, rsp0_result_d;
    logic [31:0] rsp1_result_q, rsp1_result_d;
    logic        last_q, last_d;

    logic        elig0, elig1;
    logic        grant0, grant1;

    // A slot is free when empty or being drained this very cycle.
    assign elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready) && !reset;
    assign elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready) && !reset;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            grant0 = 1'b1;
`else
            grant0 = last_q;
            grant1 = !last_q;
`endif
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_input_a           = 32'd0;
        alu_input_b           = 32'd0;
        alu_function_select   = 3'd0;
        alu_function_modifier = 1'b0;
        if (grant0) begin
            alu_input_a           = req0_a;
            alu_input_b           = req0_b;
            alu_function_select   = req0_func;
            alu_function_modifier = req0_mod;
        end else if (grant1) begin
            alu_input_a           = req1_a;
            alu_input_b           = req1_b;
            alu_function_select   = req1_func;
            alu_function_modifier = req1_mod;
        end
    end

    always_comb begin
        rsp0_valid_d  = rsp0_valid_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;
        last_d        = last_q;

        // A new grant wins over a drain, giving back-to-back throughput.
        if (grant0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
        end else if (rsp0_ready) begin
            rsp0_valid_d  = 1'b0;
        end

        if (grant1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
        end else if (rsp1_ready) begin
            rsp1_valid_d  = 1'b0;
        end

        if (grant0) begin
            last_d = 1'b0;
        end else if (grant1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= 32'd0;
            rsp1_result_q <= 32'd0;
            last_q        <= 1'b1;
        end else begin
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            last_q        <= last_d;
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 Port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 Ports `req0_valid`/`req1_valid`, input, 1 bit each: the requester presents an operation.
REQ-005 Ports `req0_ready`/`req1_ready`, output, 1 bit each: the operation is accepted this cycle.
REQ-006 Ports `req0_a`/`req1_a` and `req0_b`/`req1_b`, input, 32 bits each: ALU operands.
REQ-007 Ports `req0_func`/`req1_func`, input, 3 bits each: ALU function select (000 add/sub … 111 and/clr).
REQ-008 Ports `req0_mod`/`req1_mod`, input, 1 bit each: ALU function modifier.
REQ-009 Ports `rsp0_valid`/`rsp1_valid`, output, 1 bit each: the result register holds an undelivered result.
REQ-010 Ports `rsp0_ready`/`rsp1_ready`, input, 1 bit each: the requester consumes the result.
REQ-011 Ports `rsp0_result`/`rsp1_result`, output, 32 bits each: registered result per requester.
REQ-012 Ports `alu_input_a`/`alu_input_b` (output, 32 bits each), `alu_function_select` (output, 3 bits) and `alu_function_modifier` (output, 1 bit): drive the shared combinational ALU.
REQ-013 Port `alu_result`, input, 32 bits: combinational ALU output.

Function
REQ-014 Port i SHALL be eligible when `reqi_valid` is high and its slot is free, i.e. `rspi_valid` is low or `rspi_ready` is high in the same cycle.
REQ-015 At most one port SHALL be granted per cycle, and `reqi_ready` SHALL equal grant_i, combinational from the current inputs and state.
REQ-016 Arbitration SHALL be round-robin on a 1-bit `last` pointer: with both ports eligible, grant the port not equal to `last`; with one eligible, grant it; with none, grant neither.
REQ-017 `last` SHALL update to the granted port on every grant and hold otherwise.
REQ-018 The ALU outputs SHALL carry the granted port's a/b/func/mod; with no grant they SHALL be driven to zero.
REQ-019 On a grant to port i, `rspi_result` SHALL load `alu_result` at the same edge and `rspi_valid` SHALL be high from the next cycle, giving a latency of exactly 1 cycle.
REQ-020 `rspi_valid` SHALL clear at an edge where `rspi_ready` is high and port i is not granted.
REQ-021 A simultaneous drain and new grant on the same port SHALL keep `rspi_valid` high and load the new result, giving back-to-back throughput of 1 operation per cycle.
REQ-022 While `rspi_valid` is high and `rspi_ready` is low, `rspi_result` SHALL hold stable and port i SHALL NOT be granted.
REQ-023 A blocked port SHALL NOT consume the pointer, so the other port takes every cycle.
REQ-024 The block SHALL not inspect func/mod; every encoding is passed through unchanged.

Reset
REQ-025 While `reset` is high at an edge, `rsp0_valid` and `rsp1_valid` SHALL be 0, `rsp0_result` and `rsp1_result` SHALL be 0, and `last` SHALL be 1 so that port 0 wins the first contention.
REQ-026 A grant presented in the cycle `reset` is high SHALL be discarded; `reqi_ready` is forced to 0 during reset.
REQ-027 A result held at reset assertion SHALL be lost, with no partial delivery.

Configuration
REQ-028 The macro `ALU_ARB_FIXED_PRIORITY_EN` SHALL select the arbitration policy.
REQ-029 When `ALU_ARB_FIXED_PRIORITY_EN` is defined, port 0 SHALL always win contention; `last` is still maintained but ignored.
REQ-030 When `ALU_ARB_FIXED_PRIORITY_EN` is undefined, round-robin SHALL apply per REQ-016; all other behaviour is identical in both builds.

Verification
REQ-031 Single op: port 0 sends a=5, b=3, func=000, mod=1 -> `req0_ready`=1; the next cycle `rsp0_valid`=1 and `rsp0_result`=2; the ALU inputs equal 5 and 3 in the accept cycle.
REQ-032 Contention after reset: both ports valid (port 1 sends 0xF0 ^ 0x0F, func=100) with both rsp_ready=1 -> port 0 is granted in cycle 0 and port 1 in cycle 1, alternating; `rsp1_result`=0xFF.
REQ-033 Backpressure: port 0 holds `rsp0_ready`=0 with a result pending while both ports are valid -> port 0 is never granted, port 1 is granted every cycle, and `rsp0_result` stays constant.
REQ-034 Streaming: port 1 is valid for 4 cycles with `rsp1_ready`=1 -> 4 results are delivered on 4 consecutive cycles with no bubble (simultaneous drain and load).
REQ-035 Reset mid-operation: `reset` is asserted in the accept cycle -> `req0_ready`=0, `rsp0_valid`=0 on the following cycle, and the first post-reset contention goes to port 0.
REQ-036 Fixed-priority build: with `ALU_ARB_FIXED_PRIORITY_EN` defined and both ports valid for 3 cycles -> port 0 is granted all 3 cycles and port 1 is never granted.
